// File: rtl/lfsr_grant_sched.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_grant_sched
// Description : Round-robin burst scheduler sharing one LFSR word generator
//               among N_REQ requesters, with deferred reseed and parity check.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_grant_sched #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]       gnt,
    output logic [7:0]             dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    input  logic                   seed_load,
    input  logic [6:0]             seed_val,
    input  logic [7:0]             lfsr_word,
    output logic                   lfsr_step,
    output logic                   lfsr_load,
    output logic [6:0]             lfsr_seed,
    output logic                   parity_err
);

    localparam int         IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [6:0] C_SEED_RST = 7'h01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_seed_pend;
    logic [6:0]         r_seed_hold;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_dout_valid;
    logic               r_lfsr_load;
    logic [6:0]         r_lfsr_seed;
    logic               r_parity_err;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [LEN_W-1:0]   w_len;
    logic [IDX_W-1:0]   w_next_ptr;
    logic               w_hs;
    logic               w_word_bad;
    logic               w_owner_req;
    logic               w_burst_end;

    // Two passes give the wrapping search: first at/after the pointer, then below it.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i] && (IDX_W'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i] && (IDX_W'(i) < r_ptr)) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_next_ptr  = (r_owner == IDX_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
    assign w_hs        = r_dout_valid & dout_ready;
    assign w_owner_req = req[r_owner];
    assign w_burst_end = (w_hs && (r_cnt == LEN_W'(1))) || !w_owner_req;
    // An all-zero state is the LFSR lock-up value, so it is flagged alongside bad parity.
    assign w_word_bad  = (lfsr_word[7] != ~^lfsr_word[6:0]) || (lfsr_word[6:0] == 7'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_seed_pend  <= 1'b0;
            r_seed_hold  <= C_SEED_RST;
            r_gnt        <= '0;
            r_dout_valid <= 1'b0;
            r_lfsr_load  <= 1'b0;
            r_lfsr_seed  <= C_SEED_RST;
            r_parity_err <= 1'b0;
        end else begin
            if (seed_load) begin
                r_seed_pend <= 1'b1;
                r_seed_hold <= (seed_val == 7'h00) ? C_SEED_RST : seed_val;
            end
            if (w_hs && w_word_bad) begin
                r_parity_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_seed_pend) begin
                        r_state     <= S_LOAD;
                        r_lfsr_load <= 1'b1;
                        r_lfsr_seed <= r_seed_hold;
                        if (!seed_load) begin
                            r_seed_pend <= 1'b0;
                        end
                    end else if (w_found) begin
                        r_state      <= S_BURST;
                        r_owner      <= w_pick;
                        r_gnt        <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                        r_dout_valid <= 1'b1;
                        r_cnt        <= (w_len == '0) ? LEN_W'(1) : w_len;
                    end
                end
                S_LOAD: begin
                    r_lfsr_load <= 1'b0;
                    r_state     <= S_IDLE;
                end
                S_BURST: begin
                    if (w_burst_end) begin
                        r_state      <= S_IDLE;
                        r_gnt        <= '0;
                        r_dout_valid <= 1'b0;
                        r_ptr        <= w_next_ptr;
                    end else if (w_hs) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign dout       = lfsr_word;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_valid && (r_cnt == LEN_W'(1));
    assign lfsr_step  = w_hs;
    assign lfsr_load  = r_lfsr_load;
    assign lfsr_seed  = r_lfsr_seed;
    assign parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_grant_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_grant_sched
// Description : Directed and randomized bench for lfsr_grant_sched against a
//               cycle-level behavioural model with an LFSR datapath stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_grant_sched;

    localparam int N_REQ = 4;
    localparam int LEN_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [N_REQ-1:0]       gnt;
    logic [7:0]             dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   dout_last;
    logic                   seed_load;
    logic [6:0]             seed_val;
    logic [7:0]             lfsr_word;
    logic                   lfsr_step;
    logic                   lfsr_load;
    logic [6:0]             lfsr_seed;
    logic                   parity_err;

    logic [6:0]             env_s;
    logic                   force_bad;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_grant_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .seed_load(seed_load), .seed_val(seed_val),
        .lfsr_word(lfsr_word), .lfsr_step(lfsr_step), .lfsr_load(lfsr_load),
        .lfsr_seed(lfsr_seed), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Datapath stub standing in for the real LFSR instance.
    always @(posedge clk) begin
        if (rst)            env_s <= 7'h01;
        else if (lfsr_load) env_s <= lfsr_seed;
        else if (lfsr_step) env_s <= {env_s[5:0], env_s[6] ^ env_s[5]};
    end
    assign lfsr_word = force_bad ? 8'h81 : {~^env_s, env_s};

    // Reference model state
    int m_owner, m_left, m_ptr, m_seed, m_steps, m_pseed, m_seed_out;
    bit m_loading, m_pend, m_perr;

    logic [7:0]       acc_q[$];
    logic [6:0]       load_q[$];
    int               grant_q[$];
    logic [N_REQ-1:0] prev_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_word(input int seed, input int steps);
        int s = seed;
        logic [6:0] v;
        logic p;
        for (int n = 0; n < steps; n++)
            s = ((s * 2) % 128) + (((s / 64) + (s / 32)) % 2);
        v = s[6:0];
        p = (($countones(v) % 2) == 0);
        return {p, v};
    endfunction

    function automatic bit word_bad(input logic [7:0] w);
        logic [6:0] v = w[6:0];
        return (w[7] != (($countones(v) % 2) == 0)) || (v == 7'h00);
    endfunction

    function automatic int len_of(input int i);
        return int'(req_len[i*LEN_W +: LEN_W]);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_ptr = 0; m_seed = 1; m_steps = 0;
        m_pend = 0; m_pseed = 1; m_seed_out = 1; m_loading = 0; m_perr = 0;
    endtask

    task automatic check_outputs();
        logic [31:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("gnt", {28'd0, gnt}, e_gnt);
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_owner >= 0});
        chk("dout_last", {31'd0, dout_last}, {31'd0, (m_owner >= 0) && (m_left == 1)});
        chk("lfsr_step", {31'd0, lfsr_step}, {31'd0, (m_owner >= 0) && dout_ready});
        chk("lfsr_load", {31'd0, lfsr_load}, {31'd0, m_loading});
        chk("lfsr_seed", {25'd0, lfsr_seed}, 32'(m_seed_out));
        chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
        if (m_owner >= 0)
            chk("dout", {24'd0, dout}, force_bad ? 32'h81 : {24'd0, model_word(m_seed, m_steps)});
        if (dout_valid === 1'b1 && dout_ready) acc_q.push_back(dout);
        if (lfsr_load === 1'b1) load_q.push_back(lfsr_seed);
        if (gnt !== '0 && prev_gnt === '0)
            for (int i = 0; i < N_REQ; i++) if (gnt[i]) grant_q.push_back(i);
        prev_gnt = gnt;
    endtask

    task automatic model_advance();
        bit hs, old_pend;
        int old_pseed;
        if (rst) begin
            model_reset();
            return;
        end
        hs = (m_owner >= 0) && dout_ready;
        if (hs && word_bad(lfsr_word)) m_perr = 1;
        if (hs) m_steps++;
        old_pend  = m_pend;
        old_pseed = m_pseed;
        if (seed_load) begin
            m_pend  = 1;
            m_pseed = (seed_val == 7'h00) ? 1 : int'(seed_val);
        end
        if (m_owner >= 0) begin
            if ((hs && m_left == 1) || !req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
            end else if (hs) begin
                m_left--;
            end
        end else if (m_loading) begin
            m_loading = 0;
            m_seed    = m_seed_out;
            m_steps   = 0;
        end else if (old_pend) begin
            m_loading  = 1;
            m_seed_out = old_pseed;
            if (!seed_load) m_pend = 0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_ptr + k) % N_REQ;
                if (req[i]) begin
                    m_owner = i;
                    m_left  = (len_of(i) == 0) ? 1 : len_of(i);
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_words(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_count"}, acc_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), {24'd0, acc_q[i]}, {24'd0, exp[i]});
    endtask

    initial begin
        rst = 1'b1; req = '0; req_len = '0; dout_ready = 1'b0;
        seed_load = 1'b0; seed_val = '0; force_bad = 1'b0;
        model_reset();
        @(posedge clk); #1;
        tick();

        // single owner, three-beat burst
        rst = 1'b0; req = 4'b0001; req_len = 16'h0003; dout_ready = 1'b1; acc_q.delete();
        tick();
        chk("t1_gnt", {28'd0, gnt}, 32'h1);
        repeat (3) tick();
        req = '0;
        chk("t1_gnt_off", {28'd0, gnt}, 32'h0);
        chk_words("t1", '{8'h01, 8'h02, 8'h04});
        tick();

        // all requesting, single-beat bursts rotate
        do_reset();
        req = 4'hF; req_len = 16'h1111; acc_q.delete(); grant_q.delete();
        repeat (10) tick();
        req = '0;
        tick();
        chk_words("t2", '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10});
        chk("t2_ngrants", grant_q.size(), 5);
        for (int i = 0; i < 5 && i < grant_q.size(); i++)
            chk($sformatf("t2_grant%0d", i), grant_q[i], i % 4);

        // backpressure holds the word
        do_reset();
        req = 4'b0001; req_len = 16'h0002; dout_ready = 1'b0; acc_q.delete();
        repeat (6) tick();
        chk("t3_hold", {24'd0, dout}, 32'h01);
        chk("t3_nostep", {31'd0, lfsr_step}, 32'h0);
        dout_ready = 1'b1;
        repeat (2) tick();
        req = '0;
        tick();
        chk_words("t3", '{8'h01, 8'h02});

        // reseed during a burst is deferred
        do_reset();
        req = 4'b0001; req_len = 16'h0003; dout_ready = 1'b1; load_q.delete();
        tick();
        seed_load = 1'b1; seed_val = 7'h55;
        tick();
        seed_load = 1'b0;
        repeat (2) tick();
        chk("t4_noload", load_q.size(), 0);
        tick();
        chk("t4_load", {31'd0, lfsr_load}, 32'h1);
        chk("t4_seed", {25'd0, lfsr_seed}, 32'h55);
        acc_q.delete();
        repeat (3) tick();
        chk_words("t4", '{8'hD5});
        req = '0;
        repeat (2) tick();

        // zero seed replaced by lock-up guard value
        do_reset();
        seed_load = 1'b1; seed_val = 7'h00;
        tick();
        seed_load = 1'b0; load_q.delete();
        repeat (2) tick();
        chk("t5_nload", load_q.size(), 1);
        if (load_q.size() > 0) chk("t5_seed", {25'd0, load_q[0]}, 32'h01);
        req = 4'b0001; req_len = 16'h0007; acc_q.delete();
        repeat (8) tick();
        req = '0;
        tick();
        chk_words("t5", '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'hC1});

        // parity error is sticky until reset; reset mid-burst
        do_reset();
        req = 4'b0001; req_len = 16'h0005; dout_ready = 1'b1;
        repeat (2) tick();
        force_bad = 1'b1;
        tick();
        force_bad = 1'b0;
        chk("t6_perr", {31'd0, parity_err}, 32'h1);
        tick();
        chk("t6_perr_hold", {31'd0, parity_err}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_perr_clr", {31'd0, parity_err}, 32'h0);
        chk("t6_gnt_clr", {28'd0, gnt}, 32'h0);
        chk("t6_valid_clr", {31'd0, dout_valid}, 32'h0);
        req = '0;
        tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) req = N_REQ'($urandom);
            if ($urandom_range(0, 15) == 0) req_len = (N_REQ*LEN_W)'($urandom);
            dout_ready = ($urandom_range(0, 9) < 7);
            seed_load  = ($urandom_range(0, 19) == 0);
            seed_val   = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
            tick();
        end
        rst = 1'b0; seed_load = 1'b0; req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
